button_debouncer: RTL and testbench

// Input conditioning stage between the raw board buttons and the gate logic in Hack.
// - Synchronises each raw active-low button to clk.
// - Debounces each button with a per-bit stability counter.
// - Outputs clean active-high "pressed" levels, so the downstream Not stage can be dropped.
// - Outputs one-cycle press and release pulses for later counter and CPU test designs.
//

---
 rtl/button_debouncer_if.sv | 27 ++
 rtl/button_debouncer.sv | 76 +++++++
 tb/tb_button_debouncer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button conditioning bus: raw active-low buttons in, clean levels and edge pulses out.
// The release pulse is carried on release_pulse because "release" is a reserved
// word in SystemVerilog and cannot name a signal.
interface button_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] but;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] release_pulse;

    // Board side: drives the raw buttons, consumes the conditioned outputs.
    modport master (
        output but,
        input  pressed,
        input  press,
        input  release_pulse
    );

    // Debouncer side: samples the raw buttons, drives the conditioned outputs.
    modport slave (
        input  but,
        output pressed,
        output press,
        output release_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-button synchroniser, stability-counter debouncer and edge-pulse generator.
// Each channel is independent. A new level is accepted only after it has been
// seen at the synchroniser output for STABLE_CYCLES consecutive edges. Any
// return to the accepted level before then discards the partial count.
// Every output comes straight from a flop, so nothing combinational links the
// raw buttons to the outputs.
module button_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.slave   bus
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

    // Two-flop synchroniser. It resets to released (1) so that leaving reset
    // sees no spurious press.
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;

    // Accepted (debounced) raw level per channel, in the raw active-low sense.
    logic [WIDTH-1:0] stable_r;

    // Run length of the synchronised level differing from stable_r. It clears
    // at terminal count, so it never wraps.
    logic [CNT_W-1:0] cnt_r [WIDTH];

    // Registered outputs.
    logic [WIDTH-1:0] pressed_r;
    logic [WIDTH-1:0] press_r;
    logic [WIDTH-1:0] release_r;

    // Synchronise, count stability, accept new levels and emit one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= '1;
            sync2_r   <= '1;
            stable_r  <= '1;
            pressed_r <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r   <= bus.but;
            sync2_r   <= sync1_r;
            // Pulses default low and are raised only on the edge that accepts a level.
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    // Back at the accepted level: the bounce is rejected.
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] < TERMINAL) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    // The new level has held long enough: accept it.
                    stable_r[i]  <= sync2_r[i];
                    pressed_r[i] <= ~sync2_r[i];
                    press_r[i]   <= ~sync2_r[i];
                    release_r[i] <=  sync2_r[i];
                    cnt_r[i]     <= '0;
                end
            end
        end
    end

    assign bus.pressed       = pressed_r;
    assign bus.press         = press_r;
    assign bus.release_pulse = release_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with WIDTH=2 and STABLE_CYCLES=4.
// The reference model states the acceptance rule directly. A bit's accepted
// level flips when the last STABLE_CYCLES synchronised samples all disagree
// with it. Samples reach the debouncer two edges after they are taken.
module tb_button_debouncer;

    localparam int W = 2;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    button_debouncer_if #(.WIDTH(W)) bus ();

    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model state.
    logic [W-1:0] raw_q [$] = '{2'b11, 2'b11};
    logic [W-1:0] win_q [$];
    logic [W-1:0] m_stable    = 2'b11;
    logic [W-1:0] exp_pressed = 2'b00;
    logic [W-1:0] exp_press   = 2'b00;
    logic [W-1:0] exp_release = 2'b00;
    logic [W-1:0] m_eff;
    logic [W-1:0] m_flip;
    logic         m_all;

    // Reference model: a two-edge sample delay, then a sliding window of the last S samples.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q       = '{2'b11, 2'b11};
            win_q.delete();
            m_stable    = 2'b11;
            exp_pressed = 2'b00;
            exp_press   = 2'b00;
            exp_release = 2'b00;
        end else begin
            m_eff = raw_q.pop_front();
            raw_q.push_back(bus.but);
            win_q.push_back(m_eff);
            if (win_q.size() > S) begin
                void'(win_q.pop_front());
            end
            m_flip = 2'b00;
            if (win_q.size() == S) begin
                for (int b = 0; b < W; b++) begin
                    m_all = 1'b1;
                    for (int j = 0; j < S; j++) begin
                        if (win_q[j][b] == m_stable[b]) begin
                            m_all = 1'b0;
                        end
                    end
                    m_flip[b] = m_all;
                end
            end
            exp_press   = m_flip & m_stable;
            exp_release = m_flip & ~m_stable;
            m_stable    = m_stable ^ m_flip;
            exp_pressed = ~m_stable;
        end
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: at the falling edge compare against the model, then drive the next inputs.
    task automatic tick(input logic [W-1:0] b, input logic r);
        @(negedge clk);
        check_eq("model_pressed", bus.pressed, exp_pressed);
        check_eq("model_press", bus.press, exp_press);
        check_eq("model_release", bus.release_pulse, exp_release);
        bus.but = b;
        rst     = r;
    endtask

    logic [W-1:0] rb;
    int           hold [W];

    initial begin
        bus.but = 2'b11;

        // Held in reset with random buttons: everything stays low.
        for (int j = 0; j < 8; j++) begin
            tick(W'($urandom_range(0, 3)), 1'b0);
            check_eq("reset_pressed", bus.pressed, 2'b00);
            check_eq("reset_press", bus.press, 2'b00);
            check_eq("reset_release", bus.release_pulse, 2'b00);
        end
        tick(2'b11, 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick(2'b11, 1'b1);
            check_eq("reset_exit_press", bus.press, 2'b00);
        end

        // Clean press on bit 0: it is sampled at edge k and takes effect at k+5.
        tick(2'b10, 1'b1);
        for (int j = 0; j < 7; j++) begin
            tick(2'b10, 1'b1);
            check_eq("clean_pressed", bus.pressed, (j >= 5) ? 2'b01 : 2'b00);
            check_eq("clean_press", bus.press, (j == 5) ? 2'b01 : 2'b00);
        end
        for (int j = 0; j < 8; j++) tick(2'b11, 1'b1);

        // Bounce: three cycles low and two high, five times. None of it is accepted.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 5; j++) begin
                tick((j < 3) ? 2'b10 : 2'b11, 1'b1);
                check_eq("bounce_pressed", bus.pressed, 2'b00);
                check_eq("bounce_press", bus.press, 2'b00);
                check_eq("bounce_release", bus.release_pulse, 2'b00);
            end
        end
        tick(2'b10, 1'b1);
        for (int j = 0; j < 7; j++) begin
            tick(2'b10, 1'b1);
            check_eq("bounce_final_press", bus.press, (j == 5) ? 2'b01 : 2'b00);
        end

        // Press both buttons, then release both together.
        for (int j = 0; j < 8; j++) tick(2'b00, 1'b1);
        check_eq("both_pressed", bus.pressed, 2'b11);
        tick(2'b11, 1'b1);
        for (int j = 0; j < 7; j++) begin
            tick(2'b11, 1'b1);
            check_eq("simul_pressed", bus.pressed, (j >= 5) ? 2'b00 : 2'b11);
            check_eq("simul_release", bus.release_pulse, (j == 5) ? 2'b11 : 2'b00);
        end
        for (int j = 0; j < 4; j++) tick(2'b11, 1'b1);

        // Independence: bit 0 is held low while bit 1 bounces in short runs.
        tick(2'b00, 1'b1);
        for (int j = 0; j < 10; j++) begin
            tick({((j + 1) % 3 == 2) ? 1'b1 : 1'b0, 1'b0}, 1'b1);
            check_eq("indep_pressed", bus.pressed, {1'b0, (j >= 5) ? 1'b1 : 1'b0});
        end
        for (int j = 0; j < 8; j++) tick(2'b11, 1'b1);

        // Reset mid-operation: bit 1 is already pressed and bit 0 is partway through its count.
        for (int j = 0; j < 8; j++) tick(2'b01, 1'b1);
        check_eq("pre_rst_pressed", bus.pressed, 2'b10);
        tick(2'b00, 1'b1);
        for (int j = 0; j < 3; j++) tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);
        #1;
        check_eq("rst_mid_clear", bus.pressed, 2'b00);
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b1);
        for (int j = 0; j < 7; j++) begin
            tick(2'b00, 1'b1);
            check_eq("rst_mid_pressed", bus.pressed, (j >= 5) ? 2'b11 : 2'b00);
            check_eq("rst_mid_press", bus.press, (j == 5) ? 2'b11 : 2'b00);
        end

        // Random held levels with occasional reset pulses, checked against the model.
        rb = 2'b11;
        for (int b = 0; b < W; b++) hold[b] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++) begin
                if (hold[b] == 0) begin
                    rb[b]   = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 7);
                end else begin
                    hold[b]--;
                end
            end
            tick(rb, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
        end
        tick(2'b11, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
